// File: rtl/operand_bus_arbiter.sv
// operand_bus_arbiter
// Two requesters share one W-bit operand path into the FMA operand latch.
// IDLE picks a winner, GRANTi streams up to MAX_BURST beats, then the
// arbiter returns to IDLE so the other side gets a chance. Accepted beats
// are registered in out and offered downstream over out_valid/out_ready.
//
// Build option: define OPERAND_ARB_FIXED_PRIO_EN to make IDLE arbitration
// fixed priority (requester 1 wins ties). Without it, arbitration is
// round-robin on the last granted requester. The burst limit applies
// either way.
module operand_bus_arbiter #(
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req1,
  input  logic [W-1:0] op1,
  input  logic         req2,
  input  logic [W-1:0] op2,
  output logic         gnt1,
  output logic         gnt2,
  output logic         sel,
  output logic [W-1:0] out,
  output logic         out_valid,
  input  logic         out_ready
);

  // Wide enough to hold 0..MAX_BURST.
  localparam int CW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT1 = 2'd1,
    GRANT2 = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          sel_q, sel_d;
  logic [W-1:0]  out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] count_q, count_d;

`ifdef OPERAND_ARB_FIXED_PRIO_EN
  // No history needed: requester 1 always wins a tie.
`else
  // 0 = requester 1 was granted last, 1 = requester 2 was granted last.
  logic          last_gnt_q, last_gnt_d;
`endif

  logic          stall;
  logic          accept;
  logic          pick1;
  logic [W-1:0]  mux_op;

  // Grants drop while the output register holds data nobody is taking.
  always_comb begin
    stall  = out_valid_q && !out_ready;
    gnt1   = (state_q == GRANT1) && !stall;
    gnt2   = (state_q == GRANT2) && !stall;
    accept = (req1 && gnt1) || (req2 && gnt2);
    mux_op = sel_q ? op2 : op1;
  end

  // IDLE winner selection: tie-break on history or fixed priority.
  always_comb begin
`ifdef OPERAND_ARB_FIXED_PRIO_EN
    pick1 = req1;
`else
    pick1 = req1 && (!req2 || last_gnt_q);
`endif
  end

  // Next-state, burst counting and output register update.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    count_d     = count_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
`ifndef OPERAND_ARB_FIXED_PRIO_EN
    last_gnt_d  = last_gnt_q;
`endif

    if (accept) begin
      out_d       = mux_op;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (pick1) begin
          state_d = GRANT1;
          sel_d   = 1'b0;
        end else if (req2) begin
          state_d = GRANT2;
          sel_d   = 1'b1;
        end
      end
      GRANT1: begin
        if (!req1 || (gnt1 && (count_q == LAST_BEAT))) begin
          state_d    = IDLE;
          sel_d      = 1'b0;
          count_d    = '0;
`ifndef OPERAND_ARB_FIXED_PRIO_EN
          last_gnt_d = 1'b0;
`endif
        end else if (gnt1) begin
          count_d = count_q + CW'(1);
        end
      end
      GRANT2: begin
        if (!req2 || (gnt2 && (count_q == LAST_BEAT))) begin
          state_d    = IDLE;
          sel_d      = 1'b0;
          count_d    = '0;
`ifndef OPERAND_ARB_FIXED_PRIO_EN
          last_gnt_d = 1'b1;
`endif
        end else if (gnt2) begin
          count_d = count_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 1'b0;
        count_d = '0;
      end
    endcase
  end

  // All state registers; reset is asynchronous and drops any held operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      count_q     <= '0;
`ifndef OPERAND_ARB_FIXED_PRIO_EN
      last_gnt_q  <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
`ifndef OPERAND_ARB_FIXED_PRIO_EN
      last_gnt_q  <= last_gnt_d;
`endif
    end
  end

  assign sel       = sel_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule
